// File: rtl/fetch_unit_if.sv
// Instruction memory req/ack bus between the fetch stage (master) and instruction memory (slave).
interface fetch_unit_if;
    logic        oMem_req;
    logic [9:0]  oMem_addr;
    logic        iMem_ack;
    logic [15:0] iMem_data;

    modport master (output oMem_req, output oMem_addr, input iMem_ack, input iMem_data);
    modport slave  (input oMem_req, input oMem_addr, output iMem_ack, output iMem_data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches 16-bit words over req/ack and presents one
// instruction at a time to the decoder through a one-entry prefetch buffer.
module fetch_unit #(
    parameter logic [9:0]  RESET_VECTOR = 10'h000,
    parameter logic [15:0] BUBBLE_WORD  = 16'h0000
) (
    input  logic                Clock,
    input  logic                Reset,
    fetch_unit_if.master        mem,
    input  logic                iStall,
    input  logic                iBranch_taken,
    input  logic                iJump_taken,
    input  logic [9:0]          iBranch_dir,
    output logic [15:0]         oInstruction,
    output logic                oInstruction_valid,
    output logic [9:0]          oPC
);
    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_DRAIN} state_t;

    state_t      state, stateN;
    logic [9:0]  pc, pcN;
    logic        memReq, memReqN;
    logic [9:0]  memAddr, memAddrN;
    logic [15:0] instr, instrN;
    logic [9:0]  instrPc, instrPcN;
    logic        instrValid, instrValidN;
    logic        bufValid, bufValidN;
    logic [15:0] bufData, bufDataN;
    logic [9:0]  bufPc, bufPcN;
    logic        acked, consume, redirect;

    assign mem.oMem_req        = memReq;
    assign mem.oMem_addr       = memAddr;
    assign oInstruction        = instr;
    assign oInstruction_valid  = instrValid;
    assign oPC                 = instrPc;

    always_comb begin
        acked       = memReq & mem.iMem_ack;
        consume     = instrValid & ~iStall;
        redirect    = consume & (iBranch_taken | iJump_taken);
        stateN      = state;
        pcN         = pc;
        instrN      = instr;
        instrPcN    = instrPc;
        instrValidN = instrValid;
        bufValidN   = bufValid;
        bufDataN    = bufData;
        bufPcN      = bufPc;

        case (state)
            S_FETCH: begin
                if (acked) begin
                    instrN      = mem.iMem_data;
                    instrPcN    = memAddr;
                    instrValidN = 1'b1;
                    pcN         = pc + 10'd1;
                    stateN      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (redirect) begin
                    bufValidN   = 1'b0;
                    pcN         = iBranch_dir;
                    instrValidN = 1'b0;
                    instrN      = BUBBLE_WORD;
                    stateN      = (memReq && !mem.iMem_ack) ? S_DRAIN : S_FETCH;
                end else begin
                    if (consume && bufValid) begin
                        instrN    = bufData;
                        instrPcN  = bufPc;
                        bufValidN = 1'b0;
                    end else if (consume && acked) begin
                        instrN   = mem.iMem_data;
                        instrPcN = memAddr;
                    end else if (consume) begin
                        instrValidN = 1'b0;
                        instrN      = BUBBLE_WORD;
                        stateN      = S_FETCH;
                    end
                    // An ack that was not bypassed straight to the decoder lands in the buffer.
                    if (acked && (!consume || bufValid)) begin
                        bufDataN  = mem.iMem_data;
                        bufPcN    = memAddr;
                        bufValidN = 1'b1;
                    end
                    if (acked) begin
                        pcN = pc + 10'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (acked) begin
                    stateN = S_FETCH;
                end
            end
            default: stateN = S_FETCH;
        endcase

        // An outstanding request is never aborted and its address never moves.
        if (memReq && !mem.iMem_ack) begin
            memReqN  = 1'b1;
            memAddrN = memAddr;
        end else begin
            memReqN  = (stateN == S_FETCH) || ((stateN == S_ISSUE) && !bufValidN);
            memAddrN = pcN;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_FETCH;
            pc         <= RESET_VECTOR;
            memReq     <= 1'b0;
            memAddr    <= RESET_VECTOR;
            instr      <= BUBBLE_WORD;
            instrPc    <= '0;
            instrValid <= 1'b0;
            bufValid   <= 1'b0;
            bufData    <= '0;
            bufPc      <= '0;
        end else begin
            state      <= stateN;
            pc         <= pcN;
            memReq     <= memReqN;
            memAddr    <= memAddrN;
            instr      <= instrN;
            instrPc    <= instrPcN;
            instrValid <= instrValidN;
            bufValid   <= bufValidN;
            bufData    <= bufDataN;
            bufPc      <= bufPcN;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/prefetch, jump, drain, reset-in-drain and PC wrap.
module tb_fetch_unit;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStall, iBranch_taken, iJump_taken;
    logic [9:0]  iBranch_dir;
    logic [15:0] oInstruction, wInstruction;
    logic        oInstruction_valid, wValid;
    logic [9:0]  oPC, wPC;
    int          total = 0;
    int          bad = 0;
    int          lat = 1;
    int          waitCnt = 0;
    logic        spurAck = 1'b0;

    fetch_unit_if mif ();
    fetch_unit_if mifW ();

    fetch_unit dut (
        .Clock(Clock), .Reset(Reset), .mem(mif), .iStall(iStall),
        .iBranch_taken(iBranch_taken), .iJump_taken(iJump_taken), .iBranch_dir(iBranch_dir),
        .oInstruction(oInstruction), .oInstruction_valid(oInstruction_valid), .oPC(oPC)
    );

    fetch_unit #(.RESET_VECTOR(10'h3FE)) dutW (
        .Clock(Clock), .Reset(Reset), .mem(mifW), .iStall(1'b0),
        .iBranch_taken(1'b0), .iJump_taken(1'b0), .iBranch_dir(10'h000),
        .oInstruction(wInstruction), .oInstruction_valid(wValid), .oPC(wPC)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] expWord(input logic [9:0] a);
        case (a)
            10'd0:   return 16'h1111;
            10'd1:   return 16'h2222;
            10'd2:   return 16'h3333;
            10'd3:   return 16'h4444;
            default: return 16'hA000 + {6'd0, a};
        endcase
    endfunction

    // Memory model: ack once the request has been held for lat cycles (lat=1 -> same cycle).
    always @(posedge Clock) begin
        if (Reset) waitCnt <= 0;
        else if (mif.oMem_req && !mif.iMem_ack) waitCnt <= waitCnt + 1;
        else waitCnt <= 0;
    end
    assign mif.iMem_ack   = (mif.oMem_req && (waitCnt >= lat - 1)) || spurAck;
    assign mif.iMem_data  = expWord(mif.oMem_addr);
    assign mifW.iMem_ack  = mifW.oMem_req;
    assign mifW.iMem_data = expWord(mifW.oMem_addr);

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; iStall = 1'b0; iBranch_taken = 1'b0; iJump_taken = 1'b0;
        iBranch_dir = '0; lat = 1;
        tick(); tick();
        total++;
        if ({mif.oMem_req, mif.oMem_addr, oInstruction_valid, oInstruction, oPC} !== {1'b0, 10'h000, 1'b0, 16'h0000, 10'h000}) begin
            bad++;
            $display("FAIL reset_state got req=%b addr=%h v=%b ins=%h pc=%h exp 0/000/0/0000/000",
                     mif.oMem_req, mif.oMem_addr, oInstruction_valid, oInstruction, oPC);
        end
        Reset = 1'b0;
        tick();
        total++;
        if ({mif.oMem_req, mif.oMem_addr, oInstruction_valid} !== {1'b1, 10'h000, 1'b0}) begin
            bad++;
            $display("FAIL first_req got req=%b addr=%h v=%b exp 1/000/0", mif.oMem_req, mif.oMem_addr, oInstruction_valid);
        end
        tick();
        total++;
        if ({oInstruction_valid, oPC, oInstruction} !== {1'b1, 10'h000, 16'h1111}) begin
            bad++;
            $display("FAIL first_valid got v=%b pc=%h ins=%h exp 1/000/1111", oInstruction_valid, oPC, oInstruction);
        end
    endtask

    task automatic test_stream();
        logic [9:0]  pcs [2]   = '{10'h001, 10'h002};
        logic [15:0] words [2] = '{16'h2222, 16'h3333};
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({oInstruction_valid, oPC, oInstruction} !== {1'b1, pcs[i], words[i]}) begin
                bad++;
                $display("FAIL stream[%0d] got v=%b pc=%h ins=%h exp 1/%h/%h", i, oInstruction_valid, oPC, oInstruction, pcs[i], words[i]);
            end
        end
    endtask

    task automatic test_stall();
        total++;
        if ({mif.oMem_req, mif.oMem_addr, mif.iMem_ack} !== {1'b1, 10'h003, 1'b1}) begin
            bad++;
            $display("FAIL stall_prefetch got req=%b addr=%h ack=%b exp 1/003/1", mif.oMem_req, mif.oMem_addr, mif.iMem_ack);
        end
        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) iStall = 1'b0;
            total++;
            if ({oInstruction_valid, oPC, oInstruction, mif.oMem_req} !== {1'b1, 10'h002, 16'h3333, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold[%0d] got v=%b pc=%h ins=%h req=%b exp 1/002/3333/0",
                         i, oInstruction_valid, oPC, oInstruction, mif.oMem_req);
            end
        end
        tick();
        total++;
        if ({oPC, oInstruction, mif.oMem_req, mif.oMem_addr} !== {10'h003, 16'h4444, 1'b1, 10'h004}) begin
            bad++;
            $display("FAIL stall_release got pc=%h ins=%h req=%b addr=%h exp 003/4444/1/004", oPC, oInstruction, mif.oMem_req, mif.oMem_addr);
        end
        tick();
        total++;
        if ({oInstruction_valid, oPC, oInstruction} !== {1'b1, 10'h004, 16'hA004}) begin
            bad++;
            $display("FAIL stall_after got v=%b pc=%h ins=%h exp 1/004/a004", oInstruction_valid, oPC, oInstruction);
        end
    endtask

    task automatic test_jump();
        tick();
        total++;
        if ({oInstruction_valid, oPC, oInstruction} !== {1'b1, 10'h005, 16'hA005}) begin
            bad++;
            $display("FAIL jump_src got v=%b pc=%h ins=%h exp 1/005/a005", oInstruction_valid, oPC, oInstruction);
        end
        iJump_taken = 1'b1; iBranch_dir = 10'h120;
        tick();
        iJump_taken = 1'b0;
        total++;
        if ({oInstruction_valid, oInstruction, mif.oMem_req, mif.oMem_addr} !== {1'b0, 16'h0000, 1'b1, 10'h120}) begin
            bad++;
            $display("FAIL jump_bubble got v=%b ins=%h req=%b addr=%h exp 0/0000/1/120",
                     oInstruction_valid, oInstruction, mif.oMem_req, mif.oMem_addr);
        end
        tick();
        total++;
        if ({oInstruction_valid, oPC, oInstruction} !== {1'b1, 10'h120, 16'hA120}) begin
            bad++;
            $display("FAIL jump_target got v=%b pc=%h ins=%h exp 1/120/a120", oInstruction_valid, oPC, oInstruction);
        end
        tick();
        total++;
        if ({oInstruction_valid, oPC, oInstruction} !== {1'b1, 10'h121, 16'hA121}) begin
            bad++;
            $display("FAIL jump_next got v=%b pc=%h ins=%h exp 1/121/a121", oInstruction_valid, oPC, oInstruction);
        end
    endtask

    task automatic test_drain();
        logic [9:0] expPc;
        bit         found;
        Reset = 1'b1; lat = 3;
        tick(); tick();
        Reset = 1'b0;
        expPc = '0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (oInstruction_valid) begin
                total++;
                if (oPC !== expPc || oInstruction !== expWord(expPc)) begin
                    bad++;
                    $display("FAIL lat3_seq got pc=%h ins=%h exp %h/%h", oPC, oInstruction, expPc, expWord(expPc));
                end
                if (oPC == 10'h004) found = 1'b1;
                expPc = expPc + 10'd1;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL lat3_timeout got no valid pc=004 within 60 cycles exp pc=004");
            return;
        end
        if ({mif.oMem_req, mif.oMem_addr, mif.iMem_ack} !== {1'b1, 10'h005, 1'b0}) begin
            bad++;
            $display("FAIL drain_pre got req=%b addr=%h ack=%b exp 1/005/0", mif.oMem_req, mif.oMem_addr, mif.iMem_ack);
        end
        iBranch_taken = 1'b1; iBranch_dir = 10'h010;
        for (int i = 0; i < 2; i++) begin
            tick();
            iBranch_taken = 1'b0;
            total++;
            if ({oInstruction_valid, mif.oMem_req, mif.oMem_addr} !== {1'b0, 1'b1, 10'h005}) begin
                bad++;
                $display("FAIL drain_hold[%0d] got v=%b req=%b addr=%h exp 0/1/005", i, oInstruction_valid, mif.oMem_req, mif.oMem_addr);
            end
        end
        tick();
        total++;
        if ({oInstruction_valid, mif.oMem_req, mif.oMem_addr} !== {1'b0, 1'b1, 10'h010}) begin
            bad++;
            $display("FAIL drain_target got v=%b req=%b addr=%h exp 0/1/010", oInstruction_valid, mif.oMem_req, mif.oMem_addr);
        end
        tick(); tick(); tick();
        total++;
        if ({oInstruction_valid, oPC, oInstruction} !== {1'b1, 10'h010, 16'hA010}) begin
            bad++;
            $display("FAIL drain_valid got v=%b pc=%h ins=%h exp 1/010/a010", oInstruction_valid, oPC, oInstruction);
        end
    endtask

    task automatic test_reset_in_drain();
        iJump_taken = 1'b1; iBranch_dir = 10'h200;
        tick();
        iJump_taken = 1'b0;
        total++;
        if ({oInstruction_valid, mif.oMem_req, mif.oMem_addr} !== {1'b0, 1'b1, 10'h011}) begin
            bad++;
            $display("FAIL rid_drain got v=%b req=%b addr=%h exp 0/1/011", oInstruction_valid, mif.oMem_req, mif.oMem_addr);
        end
        Reset = 1'b1;
        tick();
        total++;
        if ({mif.oMem_req, mif.oMem_addr, oInstruction_valid, oInstruction, oPC} !== {1'b0, 10'h000, 1'b0, 16'h0000, 10'h000}) begin
            bad++;
            $display("FAIL rid_reset got req=%b addr=%h v=%b ins=%h pc=%h exp 0/000/0/0000/000",
                     mif.oMem_req, mif.oMem_addr, oInstruction_valid, oInstruction, oPC);
        end
        Reset = 1'b0; spurAck = 1'b1;
        tick();
        spurAck = 1'b0;
        total++;
        if ({oInstruction_valid, mif.oMem_req, mif.oMem_addr} !== {1'b0, 1'b1, 10'h000}) begin
            bad++;
            $display("FAIL rid_stray_ack got v=%b req=%b addr=%h exp 0/1/000", oInstruction_valid, mif.oMem_req, mif.oMem_addr);
        end
        tick(); tick(); tick();
        total++;
        if ({oInstruction_valid, oPC, oInstruction} !== {1'b1, 10'h000, 16'h1111}) begin
            bad++;
            $display("FAIL rid_restart got v=%b pc=%h ins=%h exp 1/000/1111", oInstruction_valid, oPC, oInstruction);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] pcs [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        Reset = 1'b1; lat = 1;
        tick(); tick();
        total++;
        if ({mifW.oMem_req, mifW.oMem_addr, wValid, wPC} !== {1'b0, 10'h3FE, 1'b0, 10'h000}) begin
            bad++;
            $display("FAIL wrap_reset got req=%b addr=%h v=%b pc=%h exp 0/3fe/0/000", mifW.oMem_req, mifW.oMem_addr, wValid, wPC);
        end
        Reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({wValid, wPC, wInstruction} !== {1'b1, pcs[i], expWord(pcs[i])}) begin
                bad++;
                $display("FAIL wrap_seq[%0d] got v=%b pc=%h ins=%h exp 1/%h/%h", i, wValid, wPC, wInstruction, pcs[i], expWord(pcs[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_drain();
        test_reset_in_drain();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the 10-bit program counter and requests 16-bit instruction words from instruction memory over a req/ack handshake.
- Presents one instruction at a time to the decoder, with a one-entry prefetch buffer.
- Redirects the program counter from the decoder's branch-taken / jump-taken / branch-address outputs.

Parameters:
- RESET_VECTOR, 10'h000, address of the first instruction fetched after reset.
- BUBBLE_WORD, 16'h0000, word driven on oInstruction when no valid instruction is held; must decode to the decoder's default case.

Ports:
- Clock  input  1  Single system clock; all state changes on its rising edge.
- Reset  input  1  Synchronous, active-high reset.
- iStall  input  1  Downstream hold; the current instruction is not consumed this cycle.
- iBranch_taken  input  1  From the decoder; conditional branch taken for the presented instruction.
- iJump_taken  input  1  From the decoder; unconditional jump for the presented instruction.
- iBranch_dir  input  10  From the decoder; absolute target address.
- oMem_req  output  1  Instruction memory request (registered).
- oMem_addr  output  10  Instruction memory address (registered); stable while a request is outstanding.
- iMem_ack  input  1  Memory response valid; data is returned in the same cycle.
- iMem_data  input  16  Instruction word returned by memory.
- oInstruction  output  16  Instruction word presented to the decoder.
- oInstruction_valid  output  1  oInstruction holds a real instruction.
- oPC  output  10  Address of oInstruction.

Behaviour:
- Reset (synchronous, active-high; Clock and Reset as above) forces:
  - pc = RESET_VECTOR; oMem_req = 0; oMem_addr = RESET_VECTOR.
  - oInstruction = BUBBLE_WORD; oInstruction_valid = 0; oPC = 0.
  - Prefetch buffer empty; state S_FETCH.
  - First cycle after Reset deasserts: oMem_req = 1, oMem_addr = RESET_VECTOR.
- Handshake:
  - A request is outstanding from the cycle oMem_req = 1 until the cycle iMem_ack = 1, inclusive.
  - oMem_addr must not change while a request is outstanding.
  - iMem_ack while oMem_req = 0 is ignored.
  - Requests cannot be aborted except by Reset. Instruction memory shares Reset.
- Definitions:
  - consume = oInstruction_valid & ~iStall.
  - redirect = consume & (iBranch_taken | iJump_taken). Both flags high together behaves the same as either one.
- pc is the next address to request. Each accepted ack (not discarded) sets pc = pc + 1, modulo 1024 (0x3FF wraps to 0x000).
- S_FETCH (oInstruction_valid = 0, buffer empty):
  - Request addr pc.
  - On ack: oInstruction = data, oPC = addr, valid = 1, go S_ISSUE.
- S_ISSUE (valid = 1):
  - Request addr pc while the buffer is empty and no redirect is occurring.
  - Ack with no consume: data goes into the buffer; oMem_req drops the next cycle.
  - Consume, no redirect: the next instruction is taken from the buffer if full, else from the same-cycle ack (bypass). If neither exists: valid = 0, oInstruction = BUBBLE_WORD, go S_FETCH.
  - Redirect:
    - Buffer and any same-cycle ack data are discarded; pc = iBranch_dir; valid = 0; oInstruction = BUBBLE_WORD.
    - If a request is outstanding and not acked this cycle, go S_DRAIN; otherwise go S_FETCH.
  - iStall high: oInstruction, oPC and valid hold unchanged.
- S_DRAIN:
  - oMem_req stays 1 with the old oMem_addr.
  - On ack: data discarded, go S_FETCH; next cycle oMem_addr = pc (the target).
  - oInstruction_valid = 0 throughout.
- Latency and throughput:
  - With 1-cycle ack, first valid instruction appears 2 cycles after Reset deasserts.
  - Sustained throughput is 1 instruction/cycle with no stall.
  - Redirect penalty is 1 bubble cycle (0-latency memory) plus any drain cycles.
- No instruction is ever presented twice, and none is skipped except on redirect.
- Reset mid-operation (including during S_DRAIN): reset values next cycle; any outstanding response is abandoned.

Test Plan:
- Reset; ROM[0..3] = 16'h1111, 16'h2222, 16'h3333, 16'h4444; 1-cycle ack -> valid from cycle 2; oPC 0, 1, 2, 3 on consecutive cycles with matching words.
- iStall high 3 cycles while oPC = 2 -> oInstruction stays 16'h3333, buffer fills with addr 3, oMem_req drops, pc = 4; after release, oPC = 3 next cycle, then 4.
- Jump at oPC = 5 with iBranch_dir = 10'h120 -> one bubble; next valid oPC = 10'h120; word at addr 6 never valid.
- Memory latency 3; branch at oPC = 4 to 10'h010 while addr 5 outstanding -> S_DRAIN, addr 5 data discarded, then oMem_addr = 10'h010; next valid oPC = 10'h010.
- RESET_VECTOR = 10'h3FE, no stall -> oPC sequence 3FE, 3FF, 000, 001.
- Reset asserted during S_DRAIN -> next cycle all outputs at reset values; fetch restarts at RESET_VECTOR; late ack from old request ignored.
